// File: rtl/ixu_pkg.sv
// Shared types and packet layout for the IXU multi-cycle issue queue.
package ixu_pkg;

   localparam int unsigned TAG_W    = 6;
   localparam int unsigned MC_PKT_W = 18;
   localparam int unsigned ROB_LSB  = 0;
   localparam int unsigned RS1_LSB  = 6;
   localparam int unsigned RS2_LSB  = 12;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] rob;
      logic [TAG_W-1:0] rs1;
      logic [TAG_W-1:0] rs2;
      logic             r1;
      logic             r2;
      logic             is_long;
   } mc_iq_entry_t;

   // Build the issue packet from an entry's tag fields.
   function automatic logic [MC_PKT_W-1:0] mc_pack(input mc_iq_entry_t e);
      logic [MC_PKT_W-1:0] pkt;
      pkt = '0;
      pkt[ROB_LSB +: TAG_W] = e.rob;
      pkt[RS1_LSB +: TAG_W] = e.rs1;
      pkt[RS2_LSB +: TAG_W] = e.rs2;
      return pkt;
   endfunction

endpackage

// File: rtl/ixu_mc_iq_select.sv
// Oldest-first selector: lowest set bit of the ready vector wins.
module ixu_mc_iq_select
   import ixu_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IW    = 3
) (
   input  logic [DEPTH-1:0] ready,
   output logic [DEPTH-1:0] grant,
   output logic [IW-1:0]    grant_idx,
   output logic             any
);

   // Priority scan from index 0 (oldest) upwards.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ready[i] && !any) begin
            grant[i]  = 1'b1;
            grant_idx = IW'(i);
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ixu_mc_issue_queue.sv
// Collapsing, age-ordered issue queue for the IXU multi-cycle pipe.
module ixu_mc_issue_queue
   import ixu_pkg::*;
#(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned WAKE_PORTS = 4
) (
   input  logic                        core_clock_i,
   input  logic                        core_reset_ni,
   input  logic                        core_flush_i,
   input  logic                        enq_valid_i,
   output logic                        enq_ready_o,
   input  logic [TAG_W-1:0]            enq_rob_i,
   input  logic [TAG_W-1:0]            enq_rs1_i,
   input  logic [TAG_W-1:0]            enq_rs2_i,
   input  logic                        enq_rs1_rdy_i,
   input  logic                        enq_rs2_rdy_i,
   input  logic                        enq_long_i,
   input  logic [TAG_W*WAKE_PORTS-1:0] wake_dest_i,
   input  logic [WAKE_PORTS-1:0]       wake_valid_i,
   output logic [MC_PKT_W-1:0]         data_o,
   output logic                        valid_o,
   input  logic                        busy_i
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   mc_iq_entry_t     ent_q   [DEPTH];
   mc_iq_entry_t     ent_d   [DEPTH];
   mc_iq_entry_t     shifted [DEPTH];
   mc_iq_entry_t     head;
   mc_iq_entry_t     new_ent;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic [CW-1:0]    enq_pos;
   logic             div_q;
   logic             div_d;
   logic [DEPTH-1:0] ready_vec;
   logic [DEPTH-1:0] grant;
   logic [DEPTH-1:0] move;
   logic [IW-1:0]    grant_idx;
   logic             any_ready;
   logic             issue;
   logic             enq_fire;

   // True when tag is zero or matches any valid broadcast this cycle.
   function automatic logic woken(input logic [TAG_W-1:0]            tag,
                                  input logic [TAG_W*WAKE_PORTS-1:0] dest,
                                  input logic [WAKE_PORTS-1:0]       vld);
      logic hit;
      hit = (tag == '0);
      for (int unsigned p = 0; p < WAKE_PORTS; p++) begin
         if (vld[p] && (dest[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
      end
      return hit;
   endfunction

   // Entries whose both sources are available.
   always_comb begin
      ready_vec = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ready_vec[i] = ent_q[i].valid & ent_q[i].r1 & ent_q[i].r2;
      end
   end

   ixu_mc_iq_select #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_select (
      .ready     (ready_vec),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any_ready)
   );

   // Issue decision and packet; consumption is independent of busy_i.
   always_comb begin
      head        = ent_q[grant_idx];
      issue       = any_ready & ~div_q;
      valid_o     = issue;
      data_o      = issue ? mc_pack(head) : '0;
      enq_ready_o = (count_q != CW'(DEPTH));
      enq_fire    = enq_valid_i & enq_ready_o & ~core_flush_i;
   end

   // Copy of the queue moved down one slot, used for collapse on issue.
   always_comb begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
         shifted[i] = ent_q[i+1];
      end
      shifted[DEPTH-1] = '0;
   end

   // Next-state: collapse, wakeup on the collapsed copies, then enqueue.
   always_comb begin
      // Slots at or above the granted one take the shifted copy.
      move = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (i == 0) move[i] = issue & grant[i];
         else        move[i] = move[i-1] | (issue & grant[i]);
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
         ent_d[i] = move[i] ? shifted[i] : ent_q[i];
         if (ent_d[i].valid) begin
            ent_d[i].r1 = ent_d[i].r1 | woken(ent_d[i].rs1, wake_dest_i, wake_valid_i);
            ent_d[i].r2 = ent_d[i].r2 | woken(ent_d[i].rs2, wake_dest_i, wake_valid_i);
         end
      end

      new_ent.valid   = 1'b1;
      new_ent.rob     = enq_rob_i;
      new_ent.rs1     = enq_rs1_i;
      new_ent.rs2     = enq_rs2_i;
      new_ent.r1      = enq_rs1_rdy_i | woken(enq_rs1_i, wake_dest_i, wake_valid_i);
      new_ent.r2      = enq_rs2_rdy_i | woken(enq_rs2_i, wake_dest_i, wake_valid_i);
      new_ent.is_long = enq_long_i;

      enq_pos = issue ? (count_q - CW'(1)) : count_q;
      if (enq_fire) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) == enq_pos) ent_d[i] = new_ent;
         end
      end

      count_d = count_q + CW'(enq_fire) - CW'(issue);

      div_d = div_q;
      if (issue && head.is_long) div_d = 1'b1;
      else if (div_q && !busy_i) div_d = 1'b0;

      if (core_flush_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_d[i] = '0;
         count_d = '0;
         div_d   = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
      if (!core_reset_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         count_q <= '0;
         div_q   <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         count_q <= count_d;
         div_q   <= div_d;
      end
   end

endmodule

// File: tb/tb_ixu_mc_issue_queue.sv
// Self-checking bench: directed scenarios plus random traffic vs. a queue model.
module tb_ixu_mc_issue_queue;

   localparam int DEPTH = 8;
   localparam int WP    = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        enq_valid;
   logic        enq_ready;
   logic [5:0]  enq_rob, enq_rs1, enq_rs2;
   logic        enq_rs1_rdy, enq_rs2_rdy, enq_long;
   logic [23:0] wake_dest;
   logic [3:0]  wake_valid;
   logic [17:0] data;
   logic        valid;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [5:0] rob, rs1, rs2;
      bit         r1, r2, lng;
   } m_ent_t;

   m_ent_t mq[$];
   bit     div;

   always #5 clk = ~clk;

   ixu_mc_issue_queue #(
      .DEPTH      (DEPTH),
      .WAKE_PORTS (WP)
   ) dut (
      .core_clock_i  (clk),
      .core_reset_ni (rst_n),
      .core_flush_i  (flush),
      .enq_valid_i   (enq_valid),
      .enq_ready_o   (enq_ready),
      .enq_rob_i     (enq_rob),
      .enq_rs1_i     (enq_rs1),
      .enq_rs2_i     (enq_rs2),
      .enq_rs1_rdy_i (enq_rs1_rdy),
      .enq_rs2_rdy_i (enq_rs2_rdy),
      .enq_long_i    (enq_long),
      .wake_dest_i   (wake_dest),
      .wake_valid_i  (wake_valid),
      .data_o        (data),
      .valid_o       (valid),
      .busy_i        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit woke(input logic [5:0] tag);
      bit hit;
      hit = (tag == 6'd0);
      for (int p = 0; p < WP; p++)
         if (wake_valid[p] && wake_dest[p*6 +: 6] == tag) hit = 1'b1;
      return hit;
   endfunction

   // Compare against the model, then advance the model by one clock.
   task automatic step();
      int          sel;
      bit          iss;
      logic [17:0] exp_d;
      m_ent_t      ne;
      #1;
      if (!rst_n) begin
         mq.delete();
         div = 1'b0;
      end
      sel = -1;
      for (int i = 0; i < mq.size(); i++)
         if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
      iss   = (sel >= 0) && !div;
      exp_d = iss ? {mq[sel].rs2, mq[sel].rs1, mq[sel].rob} : 18'd0;
      chk("enq_ready", 32'(enq_ready), 32'(mq.size() < DEPTH));
      chk("valid",     32'(valid),     32'(iss));
      chk("data",      32'(data),      32'(exp_d));
      if (rst_n) begin
         if (flush) begin
            mq.delete();
            div = 1'b0;
         end else begin
            bit can_enq;
            can_enq = mq.size() < DEPTH;
            if (iss) begin
               if (mq[sel].lng) div = 1'b1;
               mq.delete(sel);
            end else if (div && !busy) begin
               div = 1'b0;
            end
            for (int i = 0; i < mq.size(); i++) begin
               mq[i].r1 = mq[i].r1 | woke(mq[i].rs1);
               mq[i].r2 = mq[i].r2 | woke(mq[i].rs2);
            end
            if (enq_valid && can_enq) begin
               ne.rob = enq_rob;
               ne.rs1 = enq_rs1;
               ne.rs2 = enq_rs2;
               ne.r1  = enq_rs1_rdy | woke(enq_rs1);
               ne.r2  = enq_rs2_rdy | woke(enq_rs2);
               ne.lng = enq_long;
               mq.push_back(ne);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic set_enq(input bit v, input logic [5:0] rob, input logic [5:0] rs1, input bit r1,
                          input logic [5:0] rs2, input bit r2, input bit lng);
      enq_valid   = v;
      enq_rob     = rob;
      enq_rs1     = rs1;
      enq_rs1_rdy = r1;
      enq_rs2     = rs2;
      enq_rs2_rdy = r2;
      enq_long    = lng;
   endtask

   task automatic no_enq();
      set_enq(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n      = 1'b0;
      flush      = 1'b0;
      busy       = 1'b0;
      wake_dest  = '0;
      wake_valid = '0;
      no_enq();
      div = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(enq_ready), 32'd1);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data",  32'(data), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // Single ready entry issues the cycle after enqueue, then queue is empty.
      set_enq(1'b1, 6'd3, 6'd5, 1'b1, 6'd0, 1'b0, 1'b0);
      step();
      no_enq();
      chk("s1_valid", 32'(valid), 32'd1);
      chk("s1_data",  32'(data), 32'({6'd0, 6'd5, 6'd3}));
      step();
      chk("s1_after", 32'(valid), 32'd0);

      // Younger ready entry bypasses older waiting one; wake releases the older.
      set_enq(1'b1, 6'd1, 6'd9, 1'b0, 6'd0, 1'b0, 1'b0);
      step();
      set_enq(1'b1, 6'd2, 6'd7, 1'b1, 6'd8, 1'b1, 1'b0);
      step();
      no_enq();
      chk("s2_b_first", 32'(data[5:0]), 32'd2);
      step();
      wake_dest[0 +: 6] = 6'd9;
      wake_valid        = 4'b0001;
      step();
      wake_valid = '0;
      chk("s2_a_valid", 32'(valid), 32'd1);
      chk("s2_a_rob",   32'(data[5:0]), 32'd1);
      step();

      // Divide blocks issue until the cycle after busy first drops.
      set_enq(1'b1, 6'd4, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
      step();
      set_enq(1'b1, 6'd5, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0);
      chk("s3_long_issue", 32'(valid), 32'd1);
      step();
      no_enq();
      busy = 1'b1;
      repeat (10) step();
      busy = 1'b0;
      chk("s3_hold", 32'(valid), 32'd0);
      step();
      chk("s3_alu_valid", 32'(valid), 32'd1);
      chk("s3_alu_rob",   32'(data[5:0]), 32'd5);
      step();

      // Full queue refuses enqueue; one issue frees a slot the next cycle.
      for (int i = 0; i < DEPTH; i++) begin
         set_enq(1'b1, 6'(40 + i), 6'(20 + i), 1'b0, 6'd0, 1'b0, 1'b0);
         step();
      end
      no_enq();
      chk("s4_full", 32'(enq_ready), 32'd0);
      wake_dest[6 +: 6] = 6'd23;
      wake_valid        = 4'b0010;
      step();
      wake_valid = '0;
      chk("s4_issue",      32'(valid), 32'd1);
      chk("s4_issue_rob",  32'(data[5:0]), 32'd43);
      chk("s4_still_full", 32'(enq_ready), 32'd0);
      step();
      chk("s4_ready", 32'(enq_ready), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;

      // Same-cycle wake at enqueue marks the source ready.
      set_enq(1'b1, 6'd6, 6'd12, 1'b0, 6'd0, 1'b0, 1'b0);
      wake_dest[12 +: 6] = 6'd12;
      wake_valid         = 4'b0100;
      step();
      no_enq();
      wake_valid = '0;
      chk("s5_valid", 32'(valid), 32'd1);
      chk("s5_rob",   32'(data[5:0]), 32'd6);
      step();

      // Flush with entries held and a divide in flight.
      set_enq(1'b1, 6'd10, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
      step();
      busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_enq(1'b1, 6'(50 + i), 6'(30 + i), 1'b0, 6'd0, 1'b0, 1'b0);
         step();
      end
      no_enq();
      flush = 1'b1;
      set_enq(1'b1, 6'd60, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0);
      step();
      no_enq();
      flush = 1'b0;
      busy  = 1'b0;
      chk("s6_valid", 32'(valid), 32'd0);
      chk("s6_ready", 32'(enq_ready), 32'd1);
      set_enq(1'b1, 6'd11, 6'd3, 1'b1, 6'd4, 1'b1, 1'b0);
      step();
      no_enq();
      chk("s6_fresh_valid", 32'(valid), 32'd1);
      chk("s6_fresh_rob",   32'(data[5:0]), 32'd11);
      step();

      // Reset during a divide clears the hold immediately.
      set_enq(1'b1, 6'd12, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
      step();
      no_enq();
      busy = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      set_enq(1'b1, 6'd13, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
      step();
      no_enq();
      chk("s7_after_rst", 32'(valid), 32'd1);
      chk("s7_rob",       32'(data[5:0]), 32'd13);
      step();
      busy = 1'b0;
      step();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         set_enq($urandom_range(0, 9) < 6, 6'($urandom), 6'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 3, 6'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 1);
         for (int p = 0; p < WP; p++) begin
            wake_dest[p*6 +: 6] = 6'($urandom_range(0, 15));
            wake_valid[p]       = $urandom_range(0, 1);
         end
         busy  = $urandom_range(0, 9) < 7;
         flush = $urandom_range(0, 99) < 2;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
